// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS core: opcodes, fetch FSM states, helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Opcode 111111 with all other fields zero terminates the program.
  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFC00_0000;

  typedef enum logic [1:0] {
    FS_LOAD = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  // Sign-extended word offset of a branch, already scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: loader port, decoder/ALU feedback in, PC/instruction/status out.
// Latency: n/a (wiring only).
// Backpressure: stall is the only hold mechanism; there is no ready/valid.
// Ports: master = environment (loader, decoder, ALU); slave = fetch_unit.
interface fetch_unit_if #(
  parameter int AW = 8
);
  logic          start;
  logic          stall;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          branch;
  logic          jump;
  logic          zero;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic [31:0]   instruction;
  logic          running;
  logic          halted;
  logic          fault;
  logic [31:0]   instr_count;

  modport master (
    output start, stall, imem_we, imem_waddr, imem_wdata, branch, jump, zero,
    input  pc, pc_plus4, instruction, running, halted, fault, instr_count
  );

  modport slave (
    input  start, stall, imem_we, imem_waddr, imem_wdata, branch, jump, zero,
    output pc, pc_plus4, instruction, running, halted, fault, instr_count
  );
endinterface

// File: rtl/fetch_unit_imem_rom.sv
// Instruction store: DEPTH x 32 array, synchronous write, combinational read.
// Latency: write visible on read port the cycle after the edge; read is same-cycle.
// Backpressure: none; writes always complete when we is high.
// Ports: clk, we/waddr/wdata (loader write), raddr -> rdata (fetch read).
module imem_rom #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  // Contents survive reset so a loaded program can be rerun.
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, instruction memory, next-PC select, LOAD/RUN/HALT FSM.
// Latency: one PC update per edge; new pc/instruction visible the cycle after the edge.
// Backpressure: stall holds PC and count in RUN; loader writes accepted only in LOAD.
// Ports: clk, reset (sync, active high), bus (fetch_unit_if.slave).
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          DEPTH      = 256,
  parameter int          AW         = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
  input logic         clk,
  input logic         reset,
  fetch_unit_if.slave bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic [31:0]  cnt_q, cnt_d;

  logic [31:0]  pc_plus4;
  logic [31:0]  rom_rdata;
  logic [31:0]  instr;
  logic         rom_we;
  logic [31:0]  target;
  logic         taken;

  assign rom_we = bus.imem_we && (state_q == FS_LOAD);

  imem_rom #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk   (clk),
    .we    (rom_we),
    .waddr (bus.imem_waddr),
    .wdata (bus.imem_wdata),
    .raddr (pc_q[AW+1:2]),
    .rdata (rom_rdata)
  );

  assign pc_plus4 = pc_q + 32'd4;

  // The decoder only ever sees a real instruction while running.
  assign instr = (state_q == FS_RUN) ? rom_rdata : 32'h0000_0000;

  // Opcode bit 0 distinguishes bne from beq, inverting the zero sense.
  assign taken = bus.zero ^ instr[26];

  always_comb begin
    target = pc_plus4;
    if (bus.jump) begin
      target = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (bus.branch && taken) begin
      target = pc_plus4 + branch_offset(instr[15:0]);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FS_LOAD: begin
        if (bus.start) begin
          state_d = FS_RUN;
        end
      end
      FS_RUN: begin
        if (bus.stall) begin
          state_d = FS_RUN;
        end else if (instr == HALT_INSTR) begin
          state_d = FS_HALT;
        end else if (target[31:AW+2] != '0) begin
          // Target falls outside the memory: stop instead of fetching garbage.
          state_d = FS_HALT;
          fault_d = 1'b1;
        end else begin
          pc_d  = target;
          cnt_d = cnt_q + 32'd1;
        end
      end
      FS_HALT: begin
        state_d = FS_HALT;
      end
      default: begin
        state_d = FS_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FS_LOAD;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.instruction = instr;
  assign bus.running     = (state_q == FS_RUN);
  assign bus.halted      = (state_q == FS_HALT);
  assign bus.fault       = fault_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed programs, reference model checked every negedge, literal pins.
// Latency: model mirrors one update per rising edge.
// Backpressure: exercises stall in RUN and ignored writes outside LOAD.
module tb_fetch_unit;

  localparam int          DEPTH = 256;
  localparam int          AW    = 8;
  localparam logic [31:0] HALTW = 32'hFC00_0000;

  logic clk;
  logic reset;

  fetch_unit_if #(.AW(AW)) bus ();

  fetch_unit #(
    .DEPTH      (DEPTH),
    .AW         (AW),
    .RESET_PC   (32'h0000_0000),
    .HALT_INSTR (HALTW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // State: 0 = loading, 1 = running, 2 = halted.
  int          m_state;
  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_cnt;
  logic [31:0] m_mem [DEPTH];

  function automatic logic [31:0] m_fetch(input logic [31:0] addr);
    return m_mem[(addr / 4) % DEPTH];
  endfunction

  always @(posedge clk) begin
    logic [31:0] ins;
    logic [31:0] nxt;
    int          off;
    if (reset) begin
      m_state = 0;
      m_pc    = 32'd0;
      m_fault = 1'b0;
      m_cnt   = 32'd0;
    end else if (m_state == 0) begin
      if (bus.imem_we) m_mem[bus.imem_waddr] = bus.imem_wdata;
      if (bus.start) m_state = 1;
    end else if (m_state == 1 && !bus.stall) begin
      ins = m_fetch(m_pc);
      if (ins == HALTW) begin
        m_state = 2;
      end else begin
        nxt = m_pc + 32'd4;
        if (bus.jump) begin
          nxt = (nxt & 32'hF000_0000) | ((ins % 32'h0400_0000) * 4);
        end else if (bus.branch && (bus.zero != ins[26])) begin
          off = int'($signed(ins[15:0]));
          nxt = nxt + 32'(off * 4);
        end
        if (nxt >= DEPTH * 4) begin
          m_state = 2;
          m_fault = 1'b1;
        end else begin
          m_pc  = nxt;
          m_cnt = m_cnt + 32'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc", bus.pc, m_pc);
      chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
      chk("instruction", bus.instruction, (m_state == 1) ? m_fetch(m_pc) : 32'd0);
      chk("running", 32'(bus.running), 32'(m_state == 1));
      chk("halted", 32'(bus.halted), 32'(m_state == 2));
      chk("fault", 32'(bus.fault), 32'(m_fault));
      chk("instr_count", bus.instr_count, m_cnt);
      if (bus.running) begin
        checks++;
        if ($isunknown({bus.branch, bus.jump})) begin
          errors++;
          $display("FAIL ctrl_known branch/jump=%b%b expected known", bus.branch, bus.jump);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.start      = 1'b0;
    bus.stall      = 1'b0;
    bus.imem_we    = 1'b0;
    bus.imem_waddr = '0;
    bus.imem_wdata = '0;
    bus.branch     = 1'b0;
    bus.jump       = 1'b0;
    bus.zero       = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    bus.imem_we    = 1'b1;
    bus.imem_waddr = a;
    bus.imem_wdata = d;
    tick();
    bus.imem_we    = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic cyc(input logic br, input logic jp, input logic zr);
    bus.branch = br;
    bus.jump   = jp;
    bus.zero   = zr;
    tick();
    bus.branch = 1'b0;
    bus.jump   = 1'b0;
    bus.zero   = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n;
    n = 0;
    while (!bus.halted && n < budget) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    checks++;
    if (!bus.halted) begin
      errors++;
      $display("FAIL halt_timeout halted=%b expected 1 within %0d cycles", bus.halted, budget);
    end
  endtask

  task automatic load_prog1();
    load(8'd0, 32'h2001_0005);   // addi $1,$0,5
    load(8'd1, 32'h2002_0007);   // addi $2,$0,7
    load(8'd2, 32'h0022_1820);   // add  $3,$1,$2
    load(8'd3, HALTW);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    cmp_en = 1'b1;

    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_instr", bus.instruction, 32'h0);
    chk("rst_count", bus.instr_count, 32'h0);
    chk("rst_running", 32'(bus.running), 32'h0);

    for (int i = 0; i < DEPTH; i++) load(AW'(i), 32'h0);

    // Straight-line program ending in HALT.
    load_prog1();
    pulse_start();
    chk("p1_pc0", bus.pc, 32'h0);
    chk("p1_instr0", bus.instruction, 32'h2001_0005);
    cyc(1'b0, 1'b0, 1'b0);
    chk("p1_pc4", bus.pc, 32'h4);
    cyc(1'b0, 1'b0, 1'b0);
    chk("p1_pc8", bus.pc, 32'h8);
    cyc(1'b0, 1'b0, 1'b0);
    chk("p1_pc12", bus.pc, 32'hC);
    chk("p1_halt_instr", bus.instruction, HALTW);
    wait_halt(10);
    chk("p1_pc_final", bus.pc, 32'hC);
    chk("p1_count", bus.instr_count, 32'd3);
    chk("p1_fault", 32'(bus.fault), 32'h0);
    chk("p1_instr_halt", bus.instruction, 32'h0);

    // beq backwards.
    do_reset();
    load(8'd0, 32'h0);
    load(8'd1, 32'h0);
    load(8'd2, 32'h1000_FFFE);
    load(8'd3, HALTW);
    pulse_start();
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("beq_at8", bus.pc, 32'h8);
    cyc(1'b1, 1'b0, 1'b1);
    chk("beq_taken", bus.pc, 32'h4);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("beq_not_taken", bus.pc, 32'hC);

    // bne forward, both senses.
    do_reset();
    for (int i = 0; i < 4; i++) load(AW'(i), 32'h0);
    load(8'd4, 32'h1400_0003);
    pulse_start();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("bne_at16", bus.pc, 32'h10);
    cyc(1'b1, 1'b0, 1'b0);
    chk("bne_taken", bus.pc, 32'h20);
    do_reset();
    pulse_start();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("bne_not_taken", bus.pc, 32'h14);

    // Jumps: in range, then out of range (branch also high: jump wins).
    do_reset();
    load(8'd0, 32'h0800_0010);
    pulse_start();
    cyc(1'b1, 1'b1, 1'b1);
    chk("j_target", bus.pc, 32'h40);
    do_reset();
    load(8'd0, 32'h0BFF_FFFF);
    pulse_start();
    cyc(1'b0, 1'b1, 1'b0);
    chk("j_oor_halted", 32'(bus.halted), 32'h1);
    chk("j_oor_fault", 32'(bus.fault), 32'h1);
    chk("j_oor_pc", bus.pc, 32'h0);
    load(8'd5, 32'h1234_5678);   // ignored in HALT
    pulse_start();               // ignored in HALT
    chk("halt_sticky", 32'(bus.halted), 32'h1);

    // Stall with loader writes attempted in RUN.
    do_reset();
    chk("fault_cleared", 32'(bus.fault), 32'h0);
    load(8'd0, 32'h0);
    load(8'd1, 32'h2001_0005);
    load(8'd2, 32'h0);
    pulse_start();
    cyc(1'b0, 1'b0, 1'b0);
    bus.stall      = 1'b1;
    bus.imem_we    = 1'b1;
    bus.imem_waddr = 8'd1;
    bus.imem_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk("stall_pc", bus.pc, 32'h4);
      chk("stall_count", bus.instr_count, 32'd1);
      chk("stall_instr", bus.instruction, 32'h2001_0005);
    end
    idle();
    cyc(1'b0, 1'b0, 1'b0);
    chk("unstall_pc", bus.pc, 32'h8);
    chk("unstall_count", bus.instr_count, 32'd2);

    // Reset in the middle of a run, then rerun the retained program.
    do_reset();
    load_prog1();
    pulse_start();
    cyc(1'b0, 1'b0, 1'b0);
    chk("mid_pc4", bus.pc, 32'h4);
    do_reset();
    chk("mid_rst_running", 32'(bus.running), 32'h0);
    chk("mid_rst_pc", bus.pc, 32'h0);
    chk("mid_rst_instr", bus.instruction, 32'h0);
    chk("mid_rst_count", bus.instr_count, 32'h0);
    pulse_start();
    chk("rerun_instr0", bus.instruction, 32'h2001_0005);
    wait_halt(10);
    chk("rerun_pc", bus.pc, 32'hC);
    chk("rerun_count", bus.instr_count, 32'd3);

    tick();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the single-cycle MIPS CPU. It sits directly upstream of the main control decoder: it holds the PC, owns the instruction memory, and presents the current instruction, whose bits 31:26 drive the decoder. It consumes the decoder's jump/branch outputs plus the ALU zero flag to compute the next PC. A small LOAD/RUN/HALT state machine gates program loading, execution and termination.

Parameters:
DEPTH, 256, instruction memory size in 32-bit words (power of two, >= 2)
AW, 8, word-address width, equals log2(DEPTH)
RESET_PC, 32'h0000_0000, PC value after reset (word aligned)
HALT_INSTR, 32'hFC00_0000, instruction word (opcode 111111) that stops execution

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse, LOAD -> RUN
stall  in  1  hold PC for this cycle (RUN only)
imem_we  in  1  loader write enable (LOAD only)
imem_waddr  in  AW  loader word address
imem_wdata  in  32  loader write data
branch  in  1  from control decoder
jump  in  1  from control decoder
zero  in  1  ALU zero flag for the current instruction
pc  out  32  current PC
pc_plus4  out  32  pc + 4 (mod 2^32)
instruction  out  32  current instruction, feeds the decoder (bits 31:26)
running  out  1  state == RUN
halted  out  1  state == HALT
fault  out  1  sticky; set when halt was caused by an out-of-range PC
instr_count  out  32  number of PC advances in RUN, wraps at 2^32

Behaviour:
- Reset (sync, high): state=LOAD, pc=RESET_PC, fault=0, instr_count=0. Memory contents are not cleared.
- The instruction memory is a DEPTH x 32 array, read combinationally at word index pc[AW+1:2].
- instruction = mem[pc index] in RUN; 32'h0000_0000 (NOP) in LOAD and HALT.
- LOAD:
  - imem_we=1 writes imem_wdata to mem[imem_waddr] at the clock edge.
  - start=1 moves to RUN at the next edge; a same-cycle write still completes.
  - branch, jump, zero and stall are ignored.
- RUN next-PC priority, highest first:
  1. stall=1: pc held, count held.
  2. instruction==HALT_INSTR: go to HALT, pc held, count held.
  3. jump=1: target = {pc_plus4[31:28], instruction[25:0], 2'b00}.
  4. branch=1 and taken: target = pc_plus4 + (sign_extend(instruction[15:0]) << 2), 32-bit modulo arithmetic.
     - taken = zero XOR instruction[26], so beq (000100) branches on zero=1 and bne (000101) on zero=0.
  5. otherwise: target = pc_plus4.
- Range check applies to the selected target (cases 3-5):
  - If target[31:AW+2] != 0, go to HALT, set fault=1, pc held.
  - Otherwise pc=target and instr_count increments.
- Only one PC update per cycle; there is no multi-cycle latency. The new pc and instruction are visible the cycle after the edge.
- imem_we is ignored in RUN and HALT. start is ignored outside LOAD.
- HALT: pc, fault and instr_count are frozen. Only reset leaves HALT.
- Reset asserted mid-RUN returns to LOAD on that edge. Loaded program memory is retained.
- If branch and jump are both asserted, jump wins. X on branch/jump in RUN is a verification error; the bench asserts they are known whenever running=1.

Decomposition:
- Shared package (cpu_pkg): opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J), HALT_INSTR default, fetch state enum {LOAD, RUN, HALT}.
- One sub-module: imem_rom, the DEPTH x 32 array with a synchronous write port and a combinational read port.
- Next-PC logic and the state machine stay in fetch_unit.

Test Plan:
- Load mem[0..3] = {addi, addi, add, HALT_INSTR}, pulse start -> pc steps 0,4,8,12. Then halted=1, fault=0, pc=12, instr_count=3.
- beq at pc=8 with imm=16'hFFFE and zero=1 -> next pc=4. Same instruction with zero=0 -> pc=12.
- bne (opcode 000101) at pc=16 with imm=3: zero=0 -> pc=32; zero=1 -> pc=20.
- j with target field 26'h10 at pc=0 -> pc=0x40. With target 26'h3FFFFFF (out of range for DEPTH=256) -> halted=1, fault=1, pc unchanged.
- In RUN, hold stall=1 for 3 cycles with imem_we=1 -> pc and instr_count unchanged, memory unchanged, instruction stable.
- Assert reset at the 2nd instruction of a running program -> next cycle state LOAD, pc=0, instruction=0, instr_count=0. A new start reruns the same program from 0.
